// File: rtl/btn_mode_ctrl_pkg.sv
// Shared types for the front-panel button/mode controller.
//   btn_fsm_t  : press-handling state machine encoding
//   opr_mode_t : operation codes presented on MODE (0 = no operation)
//   BTN*_IDX   : default board button positions; button i selects mode i+1
package btn_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        COMMIT,
        RELEASE_WAIT
    } btn_fsm_t;

    typedef enum logic [2:0] {
        RESET        = 3'd0,
        MUL          = 3'd1,
        LEADING_ONES = 3'd2,
        COUNT_ONES   = 3'd3,
        ADD          = 3'd4,
        SUB          = 3'd5
    } opr_mode_t;

    localparam int unsigned BTNC_IDX = 0;
    localparam int unsigned BTNU_IDX = 1;
    localparam int unsigned BTND_IDX = 2;
    localparam int unsigned BTNL_IDX = 3;
    localparam int unsigned BTNR_IDX = 4;

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser for the raw push-button vector.
//   CLOCK      : system clock
//   CPU_RESETN : asynchronous, active-high reset; clears every stage
//   din        : raw asynchronous buttons
//   dout       : buttons after SYNC_STAGES flops
module btn_sync #(
    parameter int unsigned N_BTN       = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             CPU_RESETN,
    input  logic [N_BTN-1:0] din,
    output logic [N_BTN-1:0] dout
);

    logic [SYNC_STAGES-1:0][N_BTN-1:0] stages;

    always_ff @(posedge CLOCK or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = stages[SYNC_STAGES-1];

endmodule

// File: rtl/btn_mode_ctrl.sv
// Button-driven operation-mode controller.
// Synchronises N_BTN buttons, optionally debounces them, picks the lowest
// pressed index and registers a new mode code plus a snapshot of SW once per
// physical press.
//   CLOCK        : system clock
//   CPU_RESETN   : asynchronous, active-high reset
//   SW           : switch operand, captured on commit
//   BTN          : raw buttons, active-high
//   MODE         : registered mode, 0 = no operation, button i -> i+1
//   OPERAND      : SW captured at commit
//   MODE_CHANGED : one-cycle pulse with the first cycle of new MODE/OPERAND
//   BUSY         : registered indication that a press is being handled
// Build option: define BTN_MODE_CTRL_DEBOUNCE_EN to enable the debounce
// counter (press and release each need DEBOUNCE_CYCLES stable cycles).
// Without it, a synchronised press commits at once and the first released
// cycle re-arms the controller.
module btn_mode_ctrl import btn_mode_ctrl_pkg::*; #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    localparam int unsigned MODE_W         = $clog2(N_BTN + 1)
) (
    input  logic              CLOCK,
    input  logic              CPU_RESETN,
    input  logic [WIDTH-1:0]  SW,
    input  logic [N_BTN-1:0]  BTN,
    output logic [MODE_W-1:0] MODE,
    output logic [WIDTH-1:0]  OPERAND,
    output logic              MODE_CHANGED,
    output logic              BUSY
);

    localparam int unsigned IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("btn_mode_ctrl: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [N_BTN-1:0] bs;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] cand_q, cand_d;
    btn_fsm_t         state_q, state_d;

    logic [MODE_W-1:0] mode_d;
    logic [WIDTH-1:0]  operand_d;
    logic              changed_d;
    logic              busy_d;

    btn_sync #(
        .N_BTN      (N_BTN),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn_sync (
        .CLOCK     (CLOCK),
        .CPU_RESETN(CPU_RESETN),
        .din       (BTN),
        .dout      (bs)
    );

    // Lowest set index wins; scanning downwards leaves the lowest one last.
    always_comb begin
        cand = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (bs[i]) begin
                cand = IDX_W'(i);
            end
        end
    end

`ifdef BTN_MODE_CTRL_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bs != '0) begin
                    state_d = QUALIFY;
                    cand_d  = cand;
                    cnt_d   = CNT_W'(1);
                end
            end
            QUALIFY: begin
                // Any change of the winning button restarts the press from scratch.
                if (bs == '0 || cand != cand_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                state_d = RELEASE_WAIT;
                cnt_d   = '0;
            end
            RELEASE_WAIT: begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bs != '0) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        unique case (state_q)
            IDLE: begin
                if (bs != '0) begin
                    state_d = COMMIT;
                    cand_d  = cand;
                end
            end
            QUALIFY: begin
                state_d = IDLE;
            end
            COMMIT: begin
                state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (bs == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
`endif

    // Output decode; every output is registered below, so nothing from BTN/SW
    // reaches a port combinationally.
    always_comb begin
        mode_d    = MODE;
        operand_d = OPERAND;
        changed_d = 1'b0;
        busy_d    = (state_q != IDLE);
        if (state_q == COMMIT) begin
            mode_d    = MODE_W'(cand_q) + MODE_W'(1);
            operand_d = SW;
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            MODE         <= MODE_W'(RESET);
            OPERAND      <= '0;
            MODE_CHANGED <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            MODE         <= mode_d;
            OPERAND      <= operand_d;
            MODE_CHANGED <= changed_d;
            BUSY         <= busy_d;
        end
    end

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Scoreboard bench for btn_mode_ctrl (default parameters).
// Stimulus pushes the expected (mode, operand, cycle) of each MODE_CHANGED
// pulse; a negedge monitor pops and compares whenever a pulse appears.
module tb_btn_mode_ctrl;

`ifdef BTN_MODE_CTRL_DEBOUNCE_EN
    localparam int LAT = 7;  // SYNC_STAGES + DEBOUNCE_CYCLES + 1
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 3;  // SYNC_STAGES + 1
    localparam bit DEB = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        CPU_RESETN = 1'b1;
    logic [15:0] SW = '0;
    logic [4:0]  BTN = '0;
    logic [2:0]  MODE;
    logic [15:0] OPERAND;
    logic        MODE_CHANGED;
    logic        BUSY;

    btn_mode_ctrl dut (
        .CLOCK       (CLOCK),
        .CPU_RESETN  (CPU_RESETN),
        .SW          (SW),
        .BTN         (BTN),
        .MODE        (MODE),
        .OPERAND     (OPERAND),
        .MODE_CHANGED(MODE_CHANGED),
        .BUSY        (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  mode;
        logic [15:0] opnd;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic expect_pulse(input logic [2:0] m, input logic [15:0] op, input int at);
        exp_t e;
        e.mode = m;
        e.opnd = op;
        e.at   = at;
        q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge CLOCK) begin
        if (MODE_CHANGED === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pulse_unexpected: got pulse at cycle %0d MODE=%0d, required none",
                         cyc, MODE);
            end else begin
                mon_e = q.pop_front();
                check("pulse_cycle", cyc, mon_e.at);
                check("pulse_mode", {29'd0, MODE}, {29'd0, mon_e.mode});
                check("pulse_operand", {16'd0, OPERAND}, {16'd0, mon_e.opnd});
            end
        end
    end

    int c;

    initial begin
        // Reset held while buttons toggle.
        tick(1);
        for (int i = 0; i < 6; i++) begin
            BTN = (i % 2 == 1) ? 5'b11111 : 5'b00101;
            SW  = 16'hFFFF;
            tick(1);
            check("rst_mode", {29'd0, MODE}, 32'd0);
            check("rst_operand", {16'd0, OPERAND}, 32'd0);
            check("rst_busy", {31'd0, BUSY}, 32'd0);
            check("rst_pulse", {31'd0, MODE_CHANGED}, 32'd0);
        end
        BTN = '0;
        tick(3);
        CPU_RESETN = 1'b0;
        tick(3);

        // Single press of BTN[3]; SW change after commit must not leak through.
        SW  = 16'h00A5;
        c   = cyc;
        BTN = 5'b01000;
        expect_pulse(3'd4, 16'h00A5, c + 1 + LAT);
        tick(3);
        check("busy_before_edge3", {31'd0, BUSY}, 32'd0);
        tick(1);
        check("busy_at_edge3", {31'd0, BUSY}, 32'd1);
        tick(LAT - 2);
        SW = 16'hFFFF;
        tick(12);
        check("single_mode", {29'd0, MODE}, 32'd4);
        check("single_operand_held", {16'd0, OPERAND}, 32'h00A5);
        check("single_busy_held", {31'd0, BUSY}, 32'd1);
        BTN = '0;
        tick(12);
        check("single_busy_released", {31'd0, BUSY}, 32'd0);

        // Bounce on BTN[1]: high 2, low 1, high 20.
        SW  = 16'h1234;
        c   = cyc;
        BTN = 5'b00010;
        if (!DEB) expect_pulse(3'd2, 16'h1234, c + 4);
        tick(2);
        BTN = '0;
        tick(1);
        BTN = 5'b00010;
        expect_pulse(3'd2, 16'h1234, c + 4 + LAT);
        tick(20);
        BTN = '0;
        tick(12);
        check("bounce_mode", {29'd0, MODE}, 32'd2);

        // Three-cycle glitch on BTN[0].
        SW  = 16'h5A5A;
        c   = cyc;
        BTN = 5'b00001;
        if (!DEB) expect_pulse(3'd1, 16'h5A5A, c + 4);
        tick(3);
        BTN = '0;
        tick(12);
        check("glitch_mode", {29'd0, MODE}, DEB ? 32'd2 : 32'd1);

        // Simultaneous press: index 2 beats index 4; BTN[0] added while held.
        SW  = 16'h0F0F;
        c   = cyc;
        BTN = 5'b10100;
        expect_pulse(3'd3, 16'h0F0F, c + 1 + LAT);
        tick(LAT + 3);
        BTN = 5'b10101;
        tick(5);
        check("simul_mode_held", {29'd0, MODE}, 32'd3);
        BTN = '0;
        tick(12);
        check("simul_mode_after", {29'd0, MODE}, 32'd3);
        check("simul_busy_after", {31'd0, BUSY}, 32'd0);

        // Reset asserted just before edge 4 of a BTN[4] press, released before edge 6.
        SW  = 16'h0BEE;
        c   = cyc;
        BTN = 5'b10000;
        if (!DEB) expect_pulse(3'd5, 16'h0BEE, c + 4);
        tick(4);
        #2 CPU_RESETN = 1'b1;
        tick(1);
        check("midrst_mode", {29'd0, MODE}, 32'd0);
        check("midrst_operand", {16'd0, OPERAND}, 32'd0);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        tick(1);
        #2 CPU_RESETN = 1'b0;
        expect_pulse(3'd5, 16'h0BEE, c + 7 + LAT);
        tick(LAT + 3);
        check("midrst_mode_after", {29'd0, MODE}, 32'd5);
        BTN = '0;
        tick(12);

        // Hold BTN[0], release, press again: one pulse per physical press.
        SW  = 16'h0001;
        c   = cyc;
        BTN = 5'b00001;
        expect_pulse(3'd1, 16'h0001, c + 1 + LAT);
        tick(20);
        check("repress_mode_1", {29'd0, MODE}, 32'd1);
        BTN = '0;
        tick(12);
        SW  = 16'h0002;
        c   = cyc;
        BTN = 5'b00001;
        expect_pulse(3'd1, 16'h0002, c + 1 + LAT);
        tick(LAT + 3);
        check("repress_operand", {16'd0, OPERAND}, 32'h0002);
        BTN = '0;
        tick(12);

        check("pending_pulses", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_mode_ctrl.md
# btn_mode_ctrl

Parametrised button-driven operation-mode controller for the board front panel. It synchronises N_BTN push-buttons, debounces them, and resolves simultaneous presses by priority through a qualify/commit/release state machine. On each accepted press it registers a new mode code and a snapshot of the switch operand for the downstream operation-select datapath. Each physical press produces exactly one mode update, and switch changes after commit do not alter the held operand.

## Interface
Parameters:
- WIDTH, 16, switch/operand width
- N_BTN, 5, number of buttons; button i selects mode i+1
- SYNC_STAGES, 2, synchroniser depth (≥2)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles to qualify a press or a release (≥1)

Ports:
- CLOCK  in  1  system clock
- CPU_RESETN  in  1  reset, asynchronous, active-high
- SW  in  WIDTH  switch operand
- BTN  in  N_BTN  raw buttons, active-high, asynchronous
- MODE  out  MODE_W = $clog2(N_BTN+1)  registered mode; 0 = RESET (no operation)
- OPERAND  out  WIDTH  SW captured at commit
- MODE_CHANGED  out  1  one-cycle pulse, coincident with the first cycle of new MODE/OPERAND
- BUSY  out  1  high in QUALIFY, COMMIT and RELEASE_WAIT

## Operation
- Reset is CPU_RESETN, asynchronous, active-high; clock is CLOCK. Reset values: MODE=0, OPERAND=0, MODE_CHANGED=0, BUSY=0, FSM=IDLE, counter=0, synchroniser flops=0.
- Synchronised vector bs = BTN through SYNC_STAGES flops. The candidate is the lowest set index of bs; lowest index wins simultaneous presses.
- IDLE: bs≠0 → QUALIFY, latch candidate, counter=1.
- QUALIFY: while the candidate is unchanged and bs≠0, counter++. When counter==DEBOUNCE_CYCLES → COMMIT. If the candidate changes or bs==0 → IDLE; the press is discarded and MODE is unchanged.
- COMMIT (1 cycle): MODE←candidate+1, OPERAND←SW, MODE_CHANGED=1 → RELEASE_WAIT, counter=0.
- RELEASE_WAIT: bs==0 → counter++, otherwise counter=0. When counter==DEBOUNCE_CYCLES → IDLE. All presses in this state are ignored.
- Re-pressing the button for the current mode re-commits the same MODE, refreshes OPERAND and pulses MODE_CHANGED.
- Reset asserted mid-operation: all state returns to reset values immediately. After release, a still-held button is treated as a new press.

## Timing
- Edge 0 is the first rising edge sampling raw BTN high, assuming a stable press.
- MODE/OPERAND update and MODE_CHANGED rises at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. With defaults that is edge 7.
- BUSY rises at edge SYNC_STAGES+1.
- After raw release at edge r, IDLE is re-entered at edge r+SYNC_STAGES+DEBOUNCE_CYCLES. The next press can be accepted from the following cycle.
- MODE_CHANGED is exactly one cycle wide. Outputs are registered and have no combinational path from any input.

## Configuration
- BTN_MODE_CTRL_DEBOUNCE_EN defined: behaviour as above.
- Undefined: the debounce counter is removed.
  - IDLE with bs≠0 goes directly to COMMIT, so commit happens at edge SYNC_STAGES+1.
  - RELEASE_WAIT exits on the first cycle with bs==0.
  - DEBOUNCE_CYCLES is ignored.

## Structure
- The shared types package holds:
  - btn_fsm_t enum {IDLE, QUALIFY, COMMIT, RELEASE_WAIT}.
  - The MODE code constants, extending opr_mode_t: RESET=0, MUL=1 (BTNC), LEADING_ONES=2 (BTNU), COUNT_ONES=3 (BTND), ADD=4 (BTNL), SUB=5 (BTNR).
  - Default button index constants, in this order.
- Sub-module btn_sync: N_BTN-wide, SYNC_STAGES-deep synchroniser with async reset.
- The FSM, counter and priority encoder stay in btn_mode_ctrl.

## Test plan
All scenarios use defaults.
- Reset: hold CPU_RESETN=1, toggle BTN → MODE=0, OPERAND=0, MODE_CHANGED=0, BUSY=0 throughout.
- Single press: SW=16'h00A5, BTN[3] held 20 cycles → at edge 7 MODE=4, OPERAND=16'h00A5, one MODE_CHANGED pulse. SW changed to 16'hFFFF after commit leaves OPERAND at 16'h00A5.
- Bounce: BTN[1] high 2 cycles, low 1 cycle, then high 20 cycles → exactly one MODE_CHANGED, MODE=2. A 3-cycle glitch alone leaves MODE unchanged.
- Simultaneous: BTN=5'b10100 held → MODE=3 (index 2 wins), single pulse. Adding BTN[0] during RELEASE_WAIT → ignored.
- Reset mid-qualify: assert CPU_RESETN at edge 4 of a BTN[4] press, release it at edge 6 with the button still held → MODE stays 0 through reset, then MODE=5 with a fresh 7-edge latency.
- Macro undefined: BTN[0] press → MODE=1 at edge 3. Hold it → no second pulse. Release, then press again → a second pulse.
